move_input_conditioner: RTL and testbench

Upstream front-end for the tic-tac-toe game controller. It synchronizes and debounces the raw select and reset push-buttons, and stabilizes the 9-bit square-selection switch bus. It emits clean single-cycle move and game-reset strobes to the game FSM, which no longer polls the buttons itself. It also flags select presses made with a malformed (non-one-hot) switch pattern.

---
 rtl/move_input_conditioner.sv | 243 ++++++++++++++++++++++++
 tb/tb_move_input_conditioner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_conditioner.sv
// move_input_conditioner
//   Front-end for the tic-tac-toe game FSM. Synchronizes and debounces the
//   select and game-reset push-buttons, stabilizes the 9-bit square switch
//   bus, and turns a select press into a single-cycle move strobe (or an
//   invalid-selection strobe when the switches are not exactly one-hot).
//
// Ports
//   MAX10_CLK1_50  in   system clock (50 MHz)
//   rst            in   synchronous, active-low reset
//   key_select_n   in   raw select button, active-low, asynchronous
//   key_reset_n    in   raw game-reset button, active-low, asynchronous
//   sw[8:0]        in   raw square switches, bit i = square i (row-major)
//   move_valid     out  1-cycle pulse, accepted move
//   move_idx[3:0]  out  square index of the last accepted move (0..8)
//   move_onehot    out  one-hot pattern of the last accepted move
//   game_reset     out  1-cycle pulse on debounced reset-button press
//   invalid_sel    out  1-cycle pulse, select pressed with non-one-hot sw
//   sel_busy       out  high from an accepted select press until release

// Per-key synchronizer + debouncer. Level output starts released (1).
module move_input_conditioner_db #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic MAX10_CLK1_50,
  input  logic rst,
  input  logic i_en,
  input  logic i_raw,
  output logic o_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_sync;

  // Synchronizer flops are deliberately left out of reset.
  always_ff @(posedge MAX10_CLK1_50)
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The counter holds the number of consecutive differing samples already
  // seen; the D-th differing sample flips the level, so it never needs to
  // exceed D-1 and cannot wrap.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else if (!i_en || (w_sync == r_level)) begin
      r_cnt   <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= w_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_level = r_level;
endmodule

module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst,
  input  logic       key_select_n,
  input  logic       key_reset_n,
  input  logic [8:0] sw,
  output logic       move_valid,
  output logic [3:0] move_idx,
  output logic [8:0] move_onehot,
  output logic       game_reset,
  output logic       invalid_sel,
  output logic       sel_busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // ---------------------------------------------------------------------
  // Synchronizer warm-up. The synchronizers are not reset, so after rst
  // their contents may predate the reset. Button counting is held off
  // until SYNC_STAGES fresh samples have flushed through, which keeps the
  // press latency identical whether the key moved before or after reset.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   w_warm;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) r_warm <= '0;
    else      r_warm <= {r_warm[SYNC_STAGES-2:0], 1'b1};
  end

  assign w_warm = r_warm[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Buttons: [0] = select, [1] = game reset
  // ---------------------------------------------------------------------
  logic [1:0] w_key_raw;
  logic [1:0] w_key_lvl;
  logic [1:0] r_key_lvl_d;
  logic [1:0] w_key_press;

  assign w_key_raw = {key_reset_n, key_select_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    move_input_conditioner_db #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_db (
      .MAX10_CLK1_50(MAX10_CLK1_50),
      .rst          (rst),
      .i_en         (w_warm),
      .i_raw        (w_key_raw[k]),
      .o_level      (w_key_lvl[k])
    );
  end

  // Registered copy of the debounced levels; a press is a 1->0 step.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) r_key_lvl_d <= 2'b11;
    else      r_key_lvl_d <= w_key_lvl;
  end

  assign w_key_press = r_key_lvl_d & ~w_key_lvl;

  // ---------------------------------------------------------------------
  // Switch stabilizer. The sync pipeline and the last-sample register run
  // free (no reset), so a switch pattern held through rst is accepted
  // again DEBOUNCE_CYCLES cycles after release -- before a held select
  // key can produce its press.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][8:0] r_sw_sync;
  logic [8:0]                  w_sw_sync;
  logic [8:0]                  r_sw_last;
  logic [8:0]                  r_sw_stable;
  logic [CW-1:0]               r_sw_cnt;

  always_ff @(posedge MAX10_CLK1_50) begin
    r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], sw};
    r_sw_last <= w_sw_sync;
  end

  assign w_sw_sync = r_sw_sync[SYNC_STAGES-1];

  // r_sw_cnt counts consecutive unchanged samples and saturates at
  // DEBOUNCE_CYCLES; from the D-th one on, the sample is loaded.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      r_sw_stable <= '0;
      r_sw_cnt    <= '0;
    end else if (w_sw_sync != r_sw_last) begin
      r_sw_cnt    <= '0;
    end else begin
      if (r_sw_cnt >= CW'(DEBOUNCE_CYCLES - 1))
        r_sw_stable <= w_sw_sync;
      if (r_sw_cnt != CW'(DEBOUNCE_CYCLES))
        r_sw_cnt <= r_sw_cnt + CW'(1);
    end
  end

  // Index of the set bit; only meaningful when r_sw_stable is one-hot.
  logic [3:0] w_idx;
  logic       w_onehot;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 9; i++)
      if (r_sw_stable[i]) w_idx = 4'(i);
  end

  assign w_onehot = $onehot(r_sw_stable);

  // ---------------------------------------------------------------------
  // Select FSM
  // ---------------------------------------------------------------------
  state_t r_state, w_state_nxt;
  logic   w_move, w_invalid;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // A reset press in the same cycle swallows the select strobe, but the
  // select press is still consumed so its release is awaited.
  always_comb begin
    w_state_nxt = r_state;
    w_move      = 1'b0;
    w_invalid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_key_press[0]) begin
          w_state_nxt = S_WAIT;
          if (!w_key_press[1]) begin
            w_move    = w_onehot;
            w_invalid = ~w_onehot;
          end
        end
      end
      S_WAIT: begin
        if (w_key_lvl[0]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  logic       r_move_valid, r_game_reset, r_invalid_sel;
  logic [3:0] r_move_idx;
  logic [8:0] r_move_onehot;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      r_move_valid  <= 1'b0;
      r_game_reset  <= 1'b0;
      r_invalid_sel <= 1'b0;
      r_move_idx    <= '0;
      r_move_onehot <= '0;
    end else begin
      r_move_valid  <= w_move;
      r_game_reset  <= w_key_press[1];
      r_invalid_sel <= w_invalid;
      if (w_move) begin
        r_move_idx    <= w_idx;
        r_move_onehot <= r_sw_stable;
      end
    end
  end

  assign move_valid  = r_move_valid;
  assign move_idx    = r_move_idx;
  assign move_onehot = r_move_onehot;
  assign game_reset  = r_game_reset;
  assign invalid_sel = r_invalid_sel;
  assign sel_busy    = (r_state == S_WAIT);
endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// A cycle-level reference model derives every expected output from the
// recorded raw input history: a button level flips once the last D
// synchronized samples all disagree with it; the switch value is taken once
// D+1 consecutive synchronized samples agree.
module tb_move_input_conditioner;
  localparam int D = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_select_n, key_reset_n;
  logic [8:0] sw;
  logic       move_valid, game_reset, invalid_sel, sel_busy;
  logic [3:0] move_idx;
  logic [8:0] move_onehot;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  move_input_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .MAX10_CLK1_50(clk),
    .rst          (rst),
    .key_select_n (key_select_n),
    .key_reset_n  (key_reset_n),
    .sw           (sw),
    .move_valid   (move_valid),
    .move_idx     (move_idx),
    .move_onehot  (move_onehot),
    .game_reset   (game_reset),
    .invalid_sel  (invalid_sel),
    .sel_busy     (sel_busy)
  );

  // ---------------- reference model ----------------
  logic       hsel [4096];
  logic       hrst [4096];
  logic [8:0] hsw  [4096];
  int         t = 0;
  int         n = 0;
  logic       m_dsel = 1'b1, m_drst = 1'b1, p_sel = 1'b0, p_rst = 1'b0;
  logic       m_busy = 1'b0;
  logic [8:0] m_swst = '0;
  logic       e_mv = 1'b0, e_gr = 1'b0, e_inv = 1'b0;
  logic [3:0] e_idx = '0;
  logic [8:0] e_oh = '0;

  function automatic int ix(input int k);
    return k & 4095;
  endfunction

  function automatic logic flips(input int key, input logic deb);
    logic v;
    if (n < S + D) return 1'b0;
    for (int k = 0; k < D; k++) begin
      v = key ? hrst[ix(t-S-k)] : hsel[ix(t-S-k)];
      if (v === deb) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic sw_steady();
    for (int k = 0; k <= D; k++)
      if (hsw[ix(t-S-k)] !== hsw[ix(t-S)]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic nd_sel, nd_rst, busy_n;
    logic [8:0] one;
    one = 9'b1;
    t++;
    hsel[ix(t)] = key_select_n;
    hrst[ix(t)] = key_reset_n;
    hsw[ix(t)]  = sw;
    if (!rst) begin
      n = 0; m_dsel = 1'b1; m_drst = 1'b1; p_sel = 1'b0; p_rst = 1'b0;
      m_busy = 1'b0; m_swst = '0;
      e_mv = 1'b0; e_gr = 1'b0; e_inv = 1'b0; e_idx = '0; e_oh = '0;
    end else begin
      n++;
      e_mv = 1'b0; e_inv = 1'b0; e_gr = p_rst; busy_n = m_busy;
      if (!m_busy) begin
        if (p_sel) begin
          busy_n = 1'b1;
          if (!p_rst) begin
            if ($countones(m_swst) == 1) begin
              e_mv = 1'b1; e_oh = m_swst;
              for (int k = 0; k < 9; k++)
                if (m_swst == (one << k)) e_idx = 4'(k);
            end else e_inv = 1'b1;
          end
        end
      end else if (m_dsel) busy_n = 1'b0;
      m_busy = busy_n;
      nd_sel = flips(0, m_dsel) ? ~m_dsel : m_dsel;
      nd_rst = flips(1, m_drst) ? ~m_drst : m_drst;
      p_sel  = m_dsel & ~nd_sel;
      p_rst  = m_drst & ~nd_rst;
      m_dsel = nd_sel;
      m_drst = nd_rst;
      if (n >= D && sw_steady()) m_swst = hsw[ix(t-S)];
    end
  endtask

  function automatic logic [16:0] obs();
    return {move_valid, game_reset, invalid_sel, sel_busy, move_idx, move_onehot};
  endfunction

  function automatic logic [16:0] expv();
    return {e_mv, e_gr, e_inv, m_busy, e_idx, e_oh};
  endfunction

  // Drive inputs, advance one clock, update model, sample 1 time unit later.
  task automatic step(input logic s, input logic r, input logic [8:0] w, input logic rr);
    key_select_n = s; key_reset_n = r; sw = w; rst = rr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 9'b0, 1'b0);
      checks++;
      if (obs() !== 17'd0) begin
        errors++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs(), 17'd0);
      end
    end
  endtask

  task automatic test_clean_move();
    int mv_n = 0, mv_at = -1, busy_lo = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 9'b000010000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL clean_pre cyc=%0d got=%h exp=%h", i, obs(), expv()); end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 9'b000010000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL clean_press cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (move_valid) begin mv_n++; if (mv_at < 0) mv_at = i; end
    end
    checks++;
    if (mv_n != 1 || mv_at != 6) begin errors++; $display("FAIL clean_latency got n=%0d at=%0d exp n=1 at=6", mv_n, mv_at); end
    checks++;
    if (move_idx !== 4'd4 || move_onehot !== 9'b000010000) begin
      errors++; $display("FAIL clean_idx got idx=%0d oh=%b exp idx=4 oh=000010000", move_idx, move_onehot);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 9'b000010000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL clean_release cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (!sel_busy && busy_lo < 0) busy_lo = i;
    end
    checks++;
    if (busy_lo != 6) begin errors++; $display("FAIL clean_busy_drop got=%0d exp=6", busy_lo); end
  endtask

  task automatic test_bounce();
    int mv_n = 0, extra = 0;
    logic s;
    for (int i = 0; i < 42; i++) begin
      s = (i < 10) ? 1'b1 : (i < 22) ? ((((i-10)/2) % 2) == 1) : 1'b0;
      step(s, 1'b1, 9'b100000000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL bounce_press cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (move_valid) mv_n++;
    end
    checks++;
    if (mv_n != 1 || move_idx !== 4'd8) begin errors++; $display("FAIL bounce_move got n=%0d idx=%0d exp n=1 idx=8", mv_n, move_idx); end
    for (int i = 0; i < 32; i++) begin
      s = (i < 12) ? (((i/2) % 2) == 0) : 1'b1;
      step(s, 1'b1, 9'b100000000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL bounce_release cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (move_valid || invalid_sel || game_reset) extra++;
    end
    checks++;
    if (extra != 0 || sel_busy !== 1'b0) begin errors++; $display("FAIL bounce_release_strobes got=%0d busy=%b exp=0 busy=0", extra, sel_busy); end
  endtask

  task automatic test_invalid();
    logic [8:0] pats [2];
    int inv_n, mv_n;
    pats[0] = 9'b000000011;
    pats[1] = 9'b000000000;
    for (int p = 0; p < 2; p++) begin
      inv_n = 0; mv_n = 0;
      for (int i = 0; i < 40; i++) begin
        step(!(i >= 10 && i < 25), 1'b1, pats[p], 1'b1);
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL invalid_%0d cyc=%0d got=%h exp=%h", p, i, obs(), expv()); end
        if (invalid_sel) inv_n++;
        if (move_valid) mv_n++;
      end
      checks++;
      if (inv_n != 1 || mv_n != 0) begin errors++; $display("FAIL invalid_count_%0d got inv=%0d mv=%0d exp inv=1 mv=0", p, inv_n, mv_n); end
    end
  endtask

  task automatic test_simultaneous();
    int gr_n = 0, gr_at = -1, mv_n = 0, inv_n = 0;
    for (int i = 0; i < 40; i++) begin
      step(!(i >= 10 && i < 25), !(i >= 10 && i < 25), 9'b000000001, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL simul cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (game_reset) begin gr_n++; if (gr_at < 0) gr_at = i - 10; end
      if (move_valid) mv_n++;
      if (invalid_sel) inv_n++;
    end
    checks++;
    if (gr_n != 1 || gr_at != 6 || mv_n != 0 || inv_n != 0) begin
      errors++; $display("FAIL simul_strobes got gr=%0d at=%0d mv=%0d inv=%0d exp gr=1 at=6 mv=0 inv=0", gr_n, gr_at, mv_n, inv_n);
    end
    mv_n = 0;
    for (int i = 0; i < 30; i++) begin
      step(!(i < 15), 1'b1, 9'b000000001, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL simul_after cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (move_valid) mv_n++;
    end
    checks++;
    if (mv_n != 1 || move_idx !== 4'd0 || move_onehot !== 9'b000000001) begin
      errors++; $display("FAIL simul_after_move got n=%0d idx=%0d exp n=1 idx=0", mv_n, move_idx);
    end
  endtask

  task automatic test_rst_midop();
    int mv_n = 0, mv_at = -1;
    for (int i = 0; i < 22; i++) begin
      step(!(i >= 10), 1'b1, 9'b000001000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL rstmid_pre cyc=%0d got=%h exp=%h", i, obs(), expv()); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 9'b000001000, 1'b0);
      checks++;
      if (obs() !== 17'd0) begin errors++; $display("FAIL rstmid_zero cyc=%0d got=%h exp=%h", i, obs(), 17'd0); end
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 9'b000001000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (move_valid) begin mv_n++; if (mv_at < 0) mv_at = i; end
    end
    checks++;
    if (mv_n != 1 || mv_at != 6 || move_idx !== 4'd3) begin
      errors++; $display("FAIL rstmid_move got n=%0d at=%0d idx=%0d exp n=1 at=6 idx=3", mv_n, mv_at, move_idx);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 9'b000001000, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL rstmid_release cyc=%0d got=%h exp=%h", i, obs(), expv()); end
    end
  endtask

  task automatic test_hold_reset();
    int gr_hold = 0, gr_rel = 0;
    for (int i = 0; i < 120; i++) begin
      step(1'b1, !(i < 100), 9'b0, 1'b1);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL holdrst cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (game_reset) begin if (i < 100) gr_hold++; else gr_rel++; end
    end
    checks++;
    if (gr_hold != 1 || gr_rel != 0) begin errors++; $display("FAIL holdrst_count got hold=%0d rel=%0d exp hold=1 rel=0", gr_hold, gr_rel); end
  endtask

  task automatic test_random();
    logic       sl = 1'b1, rl = 1'b1, rr;
    logic [8:0] rsw = 9'b000100000;
    logic [8:0] one = 9'b1;
    int         rst_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) sl = ~sl;
      if ($urandom_range(0, 39) == 0) rl = ~rl;
      if ($urandom_range(0, 29) == 0)
        rsw = ($urandom_range(0, 2) != 0) ? (one << $urandom_range(0, 8)) : 9'($urandom);
      if (rst_hold > 0) begin rr = 1'b0; rst_hold--; end
      else begin
        rr = 1'b1;
        if ($urandom_range(0, 299) == 0) rst_hold = $urandom_range(1, 3);
      end
      step(sl ^ ($urandom_range(0, 9) == 0), rl ^ ($urandom_range(0, 14) == 0), rsw, rr);
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      checks++;
      if (move_valid && invalid_sel) begin errors++; $display("FAIL random_excl cyc=%0d got mv=1 inv=1 exp not both", i); end
    end
  endtask

  initial begin
    rst = 1'b0; key_select_n = 1'b1; key_reset_n = 1'b1; sw = '0;
    test_reset();
    test_clean_move();
    test_bounce();
    test_invalid();
    test_simultaneous();
    test_rst_midop();
    test_hold_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
